// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM encoding, default sizing, data-register address
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT = 104;   // 12 MHz / 115200
  localparam int UART_FIFO_DEPTH   = 16;

  // Store target decoded by the data-side write path into byte pushes.
  localparam logic [31:0] UART_DATA_ADDR = 32'h0000_0100;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous 8-bit FIFO with occupancy count
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   push, wdata    write wdata at the tail (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   rdata          head entry, combinational read
//   level          occupancy 0..DEPTH
//   full, empty    decoded from level
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers are exactly AW bits wide, so they wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid, in_data     byte push; accepted when in_ready
//   in_ready              FIFO not full (registered state only)
//   ovf_clear             clears the sticky overflow flag (a same-cycle set wins)
//   uart_tx               registered serial line, idle high
//   busy                  frame in flight or bytes queued
//   fifo_level            FIFO occupancy 0..DEPTH
//   overflow              sticky: push attempted while full
import uart_pkg::*;

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DEPTH        = UART_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   ovf_clear,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic          last_baud;

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign busy      = (state != ST_IDLE) || !empty;
  assign last_baud = (baud == BAUD_LAST);

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      uart_tx <= tx_n;
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (ovf_clear)        overflow <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (last_baud) begin
          baud_n  = '0;
          state_n = ST_DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (last_baud) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = ST_STOP;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (last_baud) begin
          baud_n = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The line level is registered from the next state so it changes on the
  // same edge as the state it belongs to.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter. It sits directly downstream of the AXI4 data-side write decode, which turns CPU stores to the UART address into byte pushes. Bytes are queued in a small synchronous FIFO so that CPU store bursts never stall on baud timing, then serialised onto `uart_tx`. It also drives the `busy` flag used for the debug LED.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200). Legal when ≥ 2.
- `DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte push request.
- `in_data`  in  8  byte to transmit.
- `in_ready`  out  1  FIFO can accept a byte this cycle.
- `ovf_clear`  in  1  clears the sticky `overflow` flag.
- `uart_tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  FIFO non-empty or a frame in flight.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was attempted while the FIFO was full.

## Operation
- **Push.** A byte is written when `in_valid && in_ready`.
  - `in_ready = (fifo_level != DEPTH)`, decoded from registered state only.
  - Upstream may ignore `in_ready`. If `in_valid && !in_ready`, the byte is dropped and `overflow` is set.
- **Overflow flag.** `overflow` is cleared by `ovf_clear`. If a set and a clear occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1; the bit counter is 3 bits.
  - **IDLE:** `uart_tx`=1. If the FIFO is non-empty, pop, load the shift register, go to START.
  - **START:** `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** `uart_tx` = shift[0], LSB first. After every CLKS_PER_BIT cycles, shift right and increment the bit counter. After bit 7, go to STOP.
  - **STOP:** `uart_tx`=1 for CLKS_PER_BIT cycles. On the last STOP cycle:
    - FIFO non-empty: pop and go straight to START (frames back-to-back, no idle gap).
    - FIFO empty: go to IDLE.
- **Pops** happen only in IDLE, or on the last STOP cycle, and only when the FIFO is non-empty.
- **Simultaneous push and pop:** `fifo_level` is unchanged. When the FIFO is full, push acceptance uses the pre-pop level, so the push is refused even if a pop occurs in that cycle.
- **Pointers:** $clog2(DEPTH) bits, natural wrap.
- `busy = (state != IDLE) || (fifo_level != 0)`.
- **Reset values:**
  - `uart_tx`=1, `in_ready`=1, `busy`=0, `fifo_level`=0, `overflow`=0.
  - FSM in IDLE; pointers and counters at 0.
- **Reset mid-frame:** the frame is aborted, the line is high from the cycle after reset, and FIFO contents are discarded.

## Timing
- **First-byte latency.** Byte accepted at edge N into an empty FIFO with FSM idle:
  - cycle N+1: FIFO non-empty, IDLE pops;
  - `uart_tx` low from cycle N+2.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles (start, 8 data bits, stop).
- **Back-to-back frames:** the next start bit follows the last stop cycle immediately.
- **Flag timing:** `busy` and `fifo_level` reflect registered state; both update one cycle after the push or pop edge.
- Throughput is at most one push per cycle. Sustained drain rate is one byte per 10·CLKS_PER_BIT cycles.

## Structure
- **Shared package `uart_pkg`:**
  - the FSM state encoding (IDLE/START/DATA/STOP);
  - default constants `UART_CLKS_PER_BIT`=104 and `UART_FIFO_DEPTH`=16;
  - the UART data-register address 32'h0000_0100, shared with the write decode.
- **Sub-module `uart_byte_fifo`:**
  - synchronous FIFO, width 8, parameter DEPTH;
  - ports: push, pop, wdata, rdata (combinational read of the head entry), level, full, empty.
- The top level holds the FSM, baud counter, bit counter, shift register, the `overflow` flag and the `uart_tx` output register.

## Test plan
- **Reset.** Hold `rst` 3 cycles with random inputs → `uart_tx`=1, `in_ready`=1, `busy`=0, `fifo_level`=0, `overflow`=0.
- **Single byte.** CLKS_PER_BIT=4, push 8'h55 at edge N → `uart_tx` low during cycles N+2..N+5, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. `busy` falls at N+42.
- **Back-to-back burst.** Push 8'h48, 8'h69, 8'h0A on consecutive cycles → three contiguous frames, 120 cycles total, no idle high between a stop bit and the next start bit.
- **Overflow.** CLKS_PER_BIT=4, DEPTH=16, `in_valid` held high for 18 cycles with distinct bytes, `in_ready` ignored by the stimulus.
  - Byte 0 pops at cycle 1, so the 17th push fills the FIFO.
  - The 18th push is dropped: `fifo_level`=16, `in_ready`=0, `overflow`=1.
  - Exactly 17 frames are transmitted, in order.
- **Overflow clear.** Pulse `ovf_clear` → `overflow`=0. Repeat with `ovf_clear` coincident with a refused push → `overflow` stays 1.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 with 5 bytes queued → `uart_tx`=1 the next cycle, `fifo_level`=0, no further frames after release.
